// File: rtl/sync_level_filter.sv
`timescale 1ns/1ps
// Deglitches an already-synchronized level: a change is accepted after FILTER_LEN consecutive samples; emits rise/fall pulses.
// Optional accepted-rise counter edge_cnt is compiled in by defining SYNC_LEVEL_FILTER_EDGE_CNT_EN.
module sync_level_filter #(
    parameter int FILTER_LEN = 4,
    parameter int EDGE_CNT_W = 16
) (
    input  logic                  clk_dest,
    input  logic                  rst_dest_n,
    input  logic                  level_in,
    input  logic                  cnt_clr,
    output logic                  level_filt,
    output logic                  pulse_rise,
    output logic                  pulse_fall,
    output logic [EDGE_CNT_W-1:0] edge_cnt
);

    generate
        if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_bad_len
            $error("sync_level_filter: FILTER_LEN must be within 2..255");
        end
    endgenerate

    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] CHECK_HIGH  = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] CHECK_LOW   = 2'd3;

    localparam logic [7:0] RUN_LAST = 8'(FILTER_LEN - 1);

    logic [1:0] state;
    logic [7:0] run_cnt;
    logic       rise_accept;
    logic       fall_accept;

    assign rise_accept = (state == CHECK_HIGH) && level_in  && (run_cnt == RUN_LAST);
    assign fall_accept = (state == CHECK_LOW)  && !level_in && (run_cnt == RUN_LAST);

    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            state      <= STABLE_LOW;
            run_cnt    <= 8'd0;
            level_filt <= 1'b0;
            pulse_rise <= 1'b0;
            pulse_fall <= 1'b0;
        end else begin
            // Pulses are single-cycle by construction: cleared unless this edge accepts a change.
            pulse_rise <= 1'b0;
            pulse_fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (level_in) begin
                        state   <= CHECK_HIGH;
                        run_cnt <= 8'd1;
                    end
                end
                CHECK_HIGH: begin
                    if (!level_in) begin
                        state   <= STABLE_LOW;
                        run_cnt <= 8'd0;
                    end else if (rise_accept) begin
                        state      <= STABLE_HIGH;
                        run_cnt    <= 8'd0;
                        level_filt <= 1'b1;
                        pulse_rise <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                end
                STABLE_HIGH: begin
                    if (!level_in) begin
                        state   <= CHECK_LOW;
                        run_cnt <= 8'd1;
                    end
                end
                CHECK_LOW: begin
                    if (level_in) begin
                        state   <= STABLE_HIGH;
                        run_cnt <= 8'd0;
                    end else if (fall_accept) begin
                        state      <= STABLE_LOW;
                        run_cnt    <= 8'd0;
                        level_filt <= 1'b0;
                        pulse_fall <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= STABLE_LOW;
                    run_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef SYNC_LEVEL_FILTER_EDGE_CNT_EN
    // A clear coinciding with an accepted rise still counts that rise.
    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= {{(EDGE_CNT_W-1){1'b0}}, rise_accept};
        end else if (rise_accept) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign edge_cnt       = '0;
`endif

endmodule

// File: doc/sync_level_filter.md
SYNC_LEVEL_FILTER -- requirements
Module: sync_level_filter

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive samples of the new level required to accept a level change; legal range 2..255.
REQ-002 Parameter EDGE_CNT_W, default 16: width of the accepted-rising-edge counter.
REQ-003 clk_dest  input  1  destination-domain clock; all flops clock on the rising edge.
REQ-004 rst_dest_n  input  1  asynchronous, active-low reset.
REQ-005 level_in  input  1  synchronized level from the upstream multi-stage level synchronizer, already in the clk_dest domain.
REQ-006 cnt_clr  input  1  synchronous clear of edge_cnt.
REQ-007 level_filt  output  1  deglitched level, registered.
REQ-008 pulse_rise  output  1  one-cycle pulse when level_filt changes 0->1, registered.
REQ-009 pulse_fall  output  1  one-cycle pulse when level_filt changes 1->0, registered.
REQ-010 edge_cnt  output  EDGE_CNT_W  count of accepted rising edges, registered.

Function
REQ-011 The FSM SHALL have four states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH and CHECK_LOW, plus an 8-bit run counter run_cnt.
REQ-012 In STABLE_LOW with level_in=1, the FSM SHALL go to CHECK_HIGH with run_cnt<=1; with level_in=0, it SHALL stay.
REQ-013 In CHECK_HIGH with level_in=0, the FSM SHALL return to STABLE_LOW with run_cnt<=0, dropping the glitch with no pulse.
REQ-014 In CHECK_HIGH with level_in=1 and run_cnt==FILTER_LEN-1, the FSM SHALL go to STABLE_HIGH, set level_filt<=1, assert pulse_rise for exactly one cycle and clear run_cnt.
REQ-015 In CHECK_HIGH with level_in=1 and run_cnt<FILTER_LEN-1, run_cnt SHALL increment.
REQ-016 STABLE_HIGH and CHECK_LOW SHALL mirror REQ-012..015 with the polarity inverted, using pulse_fall.
REQ-017 Latency: if level_in first holds the new value at edge k and keeps it through edge k+FILTER_LEN-1, level_filt and the pulse SHALL update at edge k+FILTER_LEN-1.
REQ-018 A run shorter than FILTER_LEN samples SHALL never change level_filt or pulse anything.
REQ-019 pulse_rise and pulse_fall SHALL never be high in the same cycle, and neither SHALL stay high for two consecutive cycles.
REQ-020 edge_cnt SHALL increment by 1 in the cycle pulse_rise is registered high and SHALL wrap from all-ones to 0.
REQ-021 When cnt_clr=1, edge_cnt SHALL load 0, or 1 if a rising edge is accepted on the same edge.
REQ-022 FILTER_LEN outside 2..255 SHALL cause an elaboration-time error.

Reset
REQ-023 Asserting rst_dest_n low SHALL immediately force STABLE_LOW, run_cnt=0, level_filt=0, pulse_rise=0, pulse_fall=0 and edge_cnt=0, independent of clk_dest.
REQ-024 Reset asserted mid-CHECK SHALL abandon the run with no pulse.
REQ-025 After deassertion, the first sample SHALL be taken at the next rising edge of clk_dest.
REQ-026 If level_in=1 at reset release, the block SHALL qualify it like any other run and produce a pulse_rise after FILTER_LEN samples.

Configuration
REQ-027 Macro SYNC_LEVEL_FILTER_EDGE_CNT_EN, when defined, SHALL compile in the edge_cnt counter and the cnt_clr logic per REQ-020/021.
REQ-028 When SYNC_LEVEL_FILTER_EDGE_CNT_EN is undefined, edge_cnt SHALL be tied to 0, cnt_clr SHALL be ignored, no counter flops SHALL be synthesized, and the port list SHALL be unchanged.

Verification
REQ-029 FILTER_LEN=4, level_in 0->1 held for 4 cycles -> level_filt=1 and pulse_rise=1 at the 4th sampling edge; pulse_rise=0 on the next edge; edge_cnt=1.
REQ-030 FILTER_LEN=4, level_in=1 for 3 cycles then 0 -> level_filt stays 0, no pulse, edge_cnt stays 0.
REQ-031 level_filt=1, then level_in=0 for 4 cycles -> pulse_fall one cycle, level_filt=0, edge_cnt unchanged.
REQ-032 EDGE_CNT_W=4, 16 qualified rising edges -> edge_cnt reads 15 then wraps to 0; cnt_clr coincident with the 17th rise -> edge_cnt=1.
REQ-033 rst_dest_n pulsed low between clock edges during CHECK_HIGH with run_cnt=2 -> all outputs 0 immediately; level_in held at 1 afterwards -> pulse_rise 4 edges after release.
REQ-034 Build without SYNC_LEVEL_FILTER_EDGE_CNT_EN and rerun REQ-029 -> level_filt and pulse behaviour identical; edge_cnt=0 throughout.
